// File: rtl/ps2_rx_frame_ctrl_pkg.sv
// Shared definitions for the PS/2 receive path.
// Holds the FSM state encoding, the parity mode selectors and a width helper.
// Imported by the top level, its FIFO and its interface.
package ps2_pkg;

   // Frame FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   // Parity mode selectors
   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Width of a counter that indexes n data bits (values 0..n-1), never below 1
   function automatic int bitcnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ps2_rx_frame_ctrl_if.sv
// Consumer-side handshake bundle for received PS/2 frames.
// Master drives head-of-buffer data, valid and level; slave drives ready.
// A beat transfers when rx_valid and rx_ready are both high.
interface ps2_rx_frame_ctrl_if
   import ps2_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic [LVL_W-1:0]     fifo_level;

   modport master (
      output rx_data,
      output rx_valid,
      output fifo_level,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  fifo_level,
      output rx_ready
   );

endinterface

// File: rtl/ps2_rx_frame_ctrl_fifo.sv
// Synchronous first-word-fall-through frame buffer.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: push while full is accepted only together with a pop.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_push_dat,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_dat,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_push_ok;
   logic             w_pop_ok;

   // A full buffer can still take a push when the head leaves in the same cycle
   assign w_push_ok = i_push & (~o_full | i_pop);
   assign w_pop_ok  = i_pop & ~o_empty;

   assign o_full  = (r_level == LW'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   // Head is forced to zero while empty so the output is clean out of reset
   assign o_dat   = o_empty ? '0 : r_mem[r_rd_ptr];

   // Storage array: written on accepted push, not reset
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   // Pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Occupancy: simultaneous push and pop leave the level unchanged
   always_ff @(posedge clk) begin
      if (reset) begin
         r_level <= '0;
      end else begin
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_frame_ctrl.sv
// PS/2 device-to-host receiver: sync, clock glitch filter, frame FSM, watchdog, frame buffer.
// Latency: push one cycle after the stop-bit strobe; rx_valid one cycle after that when empty.
// Backpressure: rx_ready pops the buffer; a good frame arriving while full and not popped is dropped.
module ps2_rx_frame_ctrl
   import ps2_pkg::*;
#(
   parameter int DATA_BITS      = 8,
   parameter int PARITY_MODE    = PARITY_ODD,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ps2_clk,
   input  logic                  ps2_data,
   ps2_rx_frame_ctrl_if.master   rx_if,
   output logic                  busy,
   output logic                  err_parity,
   output logic                  err_frame,
   output logic                  err_overrun,
   output logic                  err_timeout
);
   localparam int BCW = bitcnt_w(DATA_BITS);
   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int LVW = $clog2(FIFO_DEPTH + 1);

   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);
   localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
   localparam logic [WCW-1:0] WD_LAST  = WCW'(TIMEOUT_CYCLES - 1);

   // Synchroniser and filter state
   logic                 r_clk_s1, r_clk_s2;
   logic                 r_dat_s1, r_dat_s2;
   logic                 r_clk_filt, r_clk_filt_d;
   logic [FCW-1:0]       r_flt_cnt;
   logic                 w_strobe;
   logic                 w_bit;

   // Frame FSM state
   logic [1:0]           r_state;
   logic [BCW-1:0]       r_bit_cnt;
   logic [DATA_BITS-1:0] r_shreg;
   logic                 r_par_bit;
   logic [WCW-1:0]       r_wd_cnt;
   logic                 w_wd_expire;
   logic                 w_par_xor;
   logic                 w_par_ok;

   // Frame verdicts, registered so they land in the cycle after the stop strobe
   logic                 r_frame_good;
   logic                 r_err_parity;
   logic                 r_err_frame;
   logic                 r_err_timeout;

   // Buffer side
   logic                 w_push;
   logic                 w_pop;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [DATA_BITS-1:0] w_fifo_dat;
   logic [LVW-1:0]       w_fifo_level;

   // Two-flop synchronisers; idle bus level is high
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_filt   <= 1'b1;
         r_clk_filt_d <= 1'b1;
         r_flt_cnt    <= '0;
      end else begin
         r_clk_filt_d <= r_clk_filt;
         if (r_clk_s2 == r_clk_filt) begin
            r_flt_cnt <= '0;
         end else if (r_flt_cnt == FLT_LAST) begin
            r_clk_filt <= ~r_clk_filt;
            r_flt_cnt  <= '0;
         end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
         end
      end
   end

   // One-cycle strobe on the filtered falling edge; the bit is the synced data then
   assign w_strobe = r_clk_filt_d & ~r_clk_filt;
   assign w_bit    = r_dat_s2;

   // A strobe in the same cycle as expiry keeps the frame alive
   assign w_wd_expire = (r_state != ST_IDLE) && (r_wd_cnt == WD_LAST) && !w_strobe;

   // Watchdog: counts idle-bus cycles within a frame, cleared by strobes and in IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wd_cnt <= '0;
      end else if (w_strobe || (r_state == ST_IDLE)) begin
         r_wd_cnt <= '0;
      end else if (!w_wd_expire) begin
         r_wd_cnt <= r_wd_cnt + 1'b1;
      end
   end

   // Parity over data bits plus received parity bit
   assign w_par_xor = ^{r_shreg, r_par_bit};
   assign w_par_ok  = (PARITY_MODE == PARITY_NONE) ? 1'b1 :
                      (PARITY_MODE == PARITY_ODD)  ? w_par_xor : ~w_par_xor;

   // Frame FSM, advanced by the strobe; watchdog expiry aborts back to IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_bit_cnt     <= '0;
         r_shreg       <= '0;
         r_par_bit     <= 1'b0;
         r_frame_good  <= 1'b0;
         r_err_parity  <= 1'b0;
         r_err_frame   <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_frame_good  <= 1'b0;
         r_err_parity  <= 1'b0;
         r_err_frame   <= 1'b0;
         r_err_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // A high bit here is bus noise or a trailing stop bit; ignore it
               if (w_strobe && !w_bit) begin
                  r_state   <= ST_DATA;
                  r_bit_cnt <= '0;
               end
            end
            ST_DATA: begin
               if (w_strobe) begin
                  r_shreg   <= {w_bit, r_shreg[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == BIT_LAST) begin
                     r_state <= (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                  end
               end
            end
            ST_PARITY: begin
               if (w_strobe) begin
                  r_par_bit <= w_bit;
                  r_state   <= ST_STOP;
               end
            end
            default: begin
               // Stop bit: parity failure outranks a bad stop bit
               if (w_strobe) begin
                  r_state      <= ST_IDLE;
                  r_err_parity <= ~w_par_ok;
                  r_err_frame  <= w_par_ok & ~w_bit;
                  r_frame_good <= w_par_ok & w_bit;
               end
            end
         endcase
         if (w_wd_expire) begin
            r_state       <= ST_IDLE;
            r_err_timeout <= 1'b1;
         end
      end
   end

   // A good frame is stored unless the buffer is full and nothing leaves this cycle
   assign w_pop       = rx_if.rx_valid & rx_if.rx_ready;
   assign w_push      = r_frame_good & (~w_fifo_full | w_pop);
   assign err_overrun = r_frame_good & w_fifo_full & ~w_pop;

   assign err_parity  = r_err_parity;
   assign err_frame   = r_err_frame;
   assign err_timeout = r_err_timeout;
   assign busy        = (r_state != ST_IDLE);

   ps2_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_dat (r_shreg),
      .i_pop      (w_pop),
      .o_dat      (w_fifo_dat),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty),
      .o_level    (w_fifo_level)
   );

   assign rx_if.rx_data    = w_fifo_dat;
   assign rx_if.rx_valid   = ~w_fifo_empty;
   assign rx_if.fifo_level = w_fifo_level;

endmodule

// File: tb/tb_ps2_rx_frame_ctrl.sv
// Directed bench for the PS/2 frame receiver with a scoreboard of expected frames.
// A protocol-level decoder predicts each frame outcome from the bit stream driven on the pins.
// A second instance covers the 7-bit, no-parity configuration.
module tb_ps2_rx_frame_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic p_clk, p_dat, tgt;
   logic ps2_clk_a, ps2_data_a, ps2_clk_b, ps2_data_b;
   logic busy_a, err_parity_a, err_frame_a, err_overrun_a, err_timeout_a;
   logic busy_b, err_parity_b, err_frame_b, err_overrun_b, err_timeout_b;

   assign ps2_clk_a  = tgt ? 1'b1 : p_clk;
   assign ps2_data_a = tgt ? 1'b1 : p_dat;
   assign ps2_clk_b  = tgt ? p_clk : 1'b1;
   assign ps2_data_b = tgt ? p_dat : 1'b1;

   ps2_rx_frame_ctrl_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) rx_if ();
   ps2_rx_frame_ctrl_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) rx7_if ();

   ps2_rx_frame_ctrl dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk_a), .ps2_data(ps2_data_a),
      .rx_if(rx_if), .busy(busy_a), .err_parity(err_parity_a), .err_frame(err_frame_a),
      .err_overrun(err_overrun_a), .err_timeout(err_timeout_a)
   );

   ps2_rx_frame_ctrl #(.DATA_BITS(7), .PARITY_MODE(0)) dut7 (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk_b), .ps2_data(ps2_data_b),
      .rx_if(rx7_if), .busy(busy_b), .err_parity(err_parity_b), .err_frame(err_frame_b),
      .err_overrun(err_overrun_b), .err_timeout(err_timeout_b)
   );

   typedef struct packed {
      logic [1:0] kind;   // 0 nothing, 1 good frame, 2 parity error, 3 framing error
      logic [8:0] data;
   } res_t;

   int checks = 0;
   int errors = 0;
   int n_par = 0, n_frm = 0, n_ovr = 0, n_tmo = 0, n_err_b = 0;
   int exp_par = 0, exp_frm = 0, exp_ovr = 0, exp_tmo = 0;
   int lvl = 0;
   logic [7:0] sb [$];

   // Observed error pulse counters
   always @(posedge clk) begin
      if (!reset) begin
         if (err_parity_a)  n_par++;
         if (err_frame_a)   n_frm++;
         if (err_overrun_a) n_ovr++;
         if (err_timeout_a) n_tmo++;
         if (err_parity_b | err_frame_b | err_overrun_b | err_timeout_b) n_err_b++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Build the pin-level bit sequence of one frame
   function automatic logic [19:0] mk_bits(input logic [8:0] d, input int nd, input int pm,
                                           input logic flip, input logic stop, output int n);
      logic [19:0] b;
      logic [8:0]  m;
      logic        par;
      int          k;
      b = '0;
      k = 0;
      m = 9'((1 << nd) - 1);
      b[k] = 1'b0; k++;
      for (int i = 0; i < nd; i++) begin
         b[k] = d[i]; k++;
      end
      if (pm != 0) begin
         par = (pm == 1) ? ~^(d & m) : ^(d & m);
         b[k] = par ^ flip; k++;
      end
      b[k] = stop; k++;
      n = k;
      return b;
   endfunction

   // Protocol-level decode of the sampled bit stream
   function automatic res_t decode(input logic [19:0] bits, input int n, input int nd, input int pm);
      res_t       r;
      int         st, cnt;
      logic [8:0] sh;
      logic       p, ok;
      r = '0; st = 0; cnt = 0; sh = '0; p = 1'b0;
      for (int i = 0; i < n; i++) begin
         case (st)
            0: if (bits[i] == 1'b0) begin st = 1; cnt = 0; end
            1: begin
               sh = (sh >> 1) | (9'(bits[i]) << (nd - 1));
               cnt++;
               if (cnt == nd) st = (pm == 0) ? 3 : 2;
            end
            2: begin p = bits[i]; st = 3; end
            default: begin
               ok = (pm == 0) ? 1'b1 : (pm == 1) ? ((^sh ^ p) == 1'b1) : ((^sh ^ p) == 1'b0);
               if (!ok)               r.kind = 2'd2;
               else if (!bits[i])     r.kind = 2'd3;
               else begin r.kind = 2'd1; r.data = sh; end
               st = 0;
            end
         endcase
      end
      return r;
   endfunction

   // Drive bits at a 60-cycle period; optional clock-low glitch after bit g_at
   task automatic send_bits(input logic [19:0] bits, input int n, input int g_at, input int g_len);
      for (int i = 0; i < n; i++) begin
         p_dat = bits[i];
         cyc(30);
         p_clk = 1'b0;
         cyc(30);
         p_clk = 1'b1;
         if (i == g_at) begin
            cyc(10);
            p_clk = 1'b0;
            cyc(g_len);
            p_clk = 1'b1;
            cyc(20);
         end
      end
      p_dat = 1'b1;
   endtask

   // Predict the outcome into the scoreboard, then drive the frame on instance A
   task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                             input int g_at, input int g_len);
      logic [19:0] bits, eff;
      int          n, k;
      res_t        r;
      bits = mk_bits({1'b0, d}, 8, 1, flip, stop, n);
      eff = '0;
      k = 0;
      for (int i = 0; i < n; i++) begin
         eff[k] = bits[i]; k++;
         if (i == g_at && g_len >= 4) begin
            eff[k] = bits[i]; k++;
         end
      end
      r = decode(eff, k, 8, 1);
      case (r.kind)
         2'd1: if (lvl < 4) begin sb.push_back(r.data[7:0]); lvl++; end else exp_ovr++;
         2'd2: exp_par++;
         2'd3: exp_frm++;
         default: ;
      endcase
      send_bits(bits, n, g_at, g_len);
      cyc(100);
   endtask

   task automatic chk_errs(input string tag);
      chk({tag, "_par"}, n_par, exp_par);
      chk({tag, "_frm"}, n_frm, exp_frm);
      chk({tag, "_ovr"}, n_ovr, exp_ovr);
      chk({tag, "_tmo"}, n_tmo, exp_tmo);
   endtask

   // Pop every expected frame and compare in order
   task automatic drain(input string tag);
      while (sb.size() > 0) begin
         @(negedge clk);
         chk({tag, "_vld"}, rx_if.rx_valid, 1);
         chk({tag, "_dat"}, rx_if.rx_data, sb[0]);
         rx_if.rx_ready = 1'b1;
         @(posedge clk);
         #1;
         rx_if.rx_ready = 1'b0;
         void'(sb.pop_front());
         lvl--;
      end
      @(negedge clk);
      chk({tag, "_empty"}, rx_if.rx_valid, 0);
      chk({tag, "_lvl0"}, rx_if.fifo_level, 0);
   endtask

   initial begin
      logic [19:0] bits;
      int          n;
      reset = 1'b1;
      p_clk = 1'b1;
      p_dat = 1'b1;
      tgt   = 1'b0;
      rx_if.rx_ready  = 1'b0;
      rx7_if.rx_ready = 1'b0;
      cyc(5);
      chk("rst_valid", rx_if.rx_valid, 0);
      chk("rst_data", rx_if.rx_data, 0);
      chk("rst_level", rx_if.fifo_level, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_errs", {err_parity_a, err_frame_a, err_overrun_a, err_timeout_a}, 0);
      reset = 1'b0;
      cyc(5);

      // Basic good frame
      send_frame(8'h1C, 1'b0, 1'b1, -1, 0);
      chk("basic_level", rx_if.fifo_level, 1);
      chk("basic_valid", rx_if.rx_valid, 1);
      drain("basic");

      // Parity error, then framing error
      send_frame(8'h1C, 1'b1, 1'b1, -1, 0);
      chk_errs("parity");
      chk("parity_level", rx_if.fifo_level, 0);
      send_frame(8'hF0, 1'b0, 1'b0, -1, 0);
      chk_errs("frame");
      chk("frame_level", rx_if.fifo_level, 0);

      // Fill and overrun
      for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b0, 1'b1, -1, 0);
      chk("ovr_level", rx_if.fifo_level, 4);
      chk_errs("ovr");
      drain("ovr");

      // Full buffer with a pop in the push cycle: no overrun
      for (int v = 8'h11; v <= 8'h14; v++) send_frame(8'(v), 1'b0, 1'b1, -1, 0);
      bits = mk_bits(9'h015, 8, 1, 1'b0, 1'b1, n);
      fork
         send_bits(bits, n, -1, 0);
         begin : popper
            int t;
            t = 0;
            while (busy_a !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
            while (busy_a !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
            chk("popper_wait", 32'(t < 2000), 1);
            chk("popper_head", rx_if.rx_data, sb[0]);
            rx_if.rx_ready = 1'b1;
            @(posedge clk);
            #1;
            rx_if.rx_ready = 1'b0;
            void'(sb.pop_front());
            sb.push_back(8'h15);
         end
      join
      cyc(100);
      chk("popfull_level", rx_if.fifo_level, 4);
      chk_errs("popfull");
      drain("popfull");

      // Watchdog: start plus four data bits then a silent bus
      bits = mk_bits(9'h01C, 8, 1, 1'b0, 1'b1, n);
      send_bits(bits, 5, -1, 0);
      cyc(4000);
      chk("wd_busy_mid", busy_a, 1);
      cyc(1100);
      exp_tmo++;
      chk_errs("wd");
      chk("wd_busy_end", busy_a, 0);
      send_frame(8'hF0, 1'b0, 1'b1, -1, 0);
      drain("wd_after");

      // Short clock glitch is filtered; a long one is a real edge
      send_frame(8'h1C, 1'b0, 1'b1, 3, 3);
      chk_errs("glitch3");
      drain("glitch3");
      send_frame(8'h1C, 1'b0, 1'b1, 4, 4);
      chk_errs("glitch4");
      drain("glitch4");

      // Reset in the middle of a frame
      bits = mk_bits(9'h0AA, 8, 1, 1'b0, 1'b1, n);
      send_bits(bits, 7, -1, 0);
      chk("midrst_busy_pre", busy_a, 1);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(2);
      chk("midrst_busy", busy_a, 0);
      chk("midrst_level", rx_if.fifo_level, 0);
      chk_errs("midrst");
      send_frame(8'hAA, 1'b0, 1'b1, -1, 0);
      drain("after_rst");
      chk_errs("after_rst");

      // Seven data bits, no parity
      tgt = 1'b1;
      bits = mk_bits(9'h055, 7, 0, 1'b0, 1'b1, n);
      send_bits(bits, n, -1, 0);
      cyc(100);
      chk("b_valid", rx7_if.rx_valid, 1);
      chk("b_data", rx7_if.rx_data, 7'h55);
      chk("b_level", rx7_if.fifo_level, 1);
      chk("b_errs", n_err_b, 0);
      tgt = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_rx_frame_ctrl.md
Name: ps2_rx_frame_ctrl

Overview:
Parametrised PS/2 device-to-host receiver that runs entirely in the system clock domain. It synchronises and glitch-filters the raw ps2_clk/ps2_data pins, then frames start/data/parity/stop bits with a single FSM. It adds a bit-timeout watchdog and error reporting, and buffers good frames in a small FIFO with a valid/ready interface. It replaces the earlier per-bit controller plus external shift register.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first (range 5..9)
PARITY_MODE, 1, 0 = no parity bit, 1 = odd, 2 = even
FILTER_LEN, 4, consecutive identical synced samples needed to change the filtered ps2_clk (>=1)
TIMEOUT_CYCLES, 5000, clk cycles without a falling edge before a partial frame is aborted
FIFO_DEPTH, 4, frame buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
rx_data  out  DATA_BITS  head-of-FIFO frame data
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts rx_data this cycle
fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries
busy  out  1  FSM not in IDLE
err_parity  out  1  1-cycle pulse: parity mismatch, frame dropped
err_frame  out  1  1-cycle pulse: stop bit sampled 0, frame dropped
err_overrun  out  1  1-cycle pulse: good frame arrived with FIFO full, frame dropped
err_timeout  out  1  1-cycle pulse: partial frame aborted by watchdog

Behaviour:
- Reset: sync and filter registers = 1 (bus idle); state = IDLE; FIFO empty; timeout counter = 0; all outputs 0 (rx_data = 0). Reset mid-frame discards the partial frame with no error pulse.
- Synchroniser: two flops per pin. ps2_data is used only after synchronisation.
- Clock filter: counter of consecutive synced ps2_clk samples that differ from the filtered value. When the count reaches FILTER_LEN the filtered value toggles and the counter clears. Any matching sample clears the counter.
- Strobe: asserted for 1 cycle when the filtered clock goes 1->0. The data bit is the synced ps2_data in that cycle.
- FSM, advancing only on strobe:
  - IDLE: bit 0 -> DATA with bit_cnt = 0. Bit 1 -> stay in IDLE, no error.
  - DATA: shift the bit into the MSB of shreg, shifting right, so the first bit lands at bit 0 after DATA_BITS shifts. bit_cnt++. After the DATA_BITS-th bit go to PARITY, or to STOP if PARITY_MODE = 0.
  - PARITY: store the parity bit -> STOP.
  - STOP: evaluate and go to IDLE. Priority: parity bad -> err_parity; else stop bit 0 -> err_frame; else FIFO full and no pop this cycle -> err_overrun; else push shreg.
- Parity: odd mode is good when the XOR of the data bits and the parity bit is 1. Even mode is good when that XOR is 0.
- Watchdog: the counter clears on every strobe and while in IDLE. Outside IDLE, when it reaches TIMEOUT_CYCLES-1 the FSM goes to IDLE, err_timeout pulses and the partial frame is discarded. If a strobe lands in the same cycle as the expiry, the strobe wins.
- Latency: a push happens in the cycle after the stop-bit strobe. rx_valid rises the following cycle when the FIFO was empty.
- FIFO:
  - First-word-fall-through: rx_data = head, rx_valid = !empty.
  - A pop happens when rx_valid && rx_ready.
  - Push and pop in the same cycle are both honoured, including when full; level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Error pulses are mutually exclusive within a frame and never coincide with a push.

Decomposition:
- Package ps2_pkg holds:
  - the state encoding (IDLE, DATA, PARITY, STOP);
  - PARITY_NONE / PARITY_ODD / PARITY_EVEN constants;
  - a bit-count width function.
- Sub-module ps2_rx_fifo: synchronous FWFT FIFO parametrised by width and depth, with push, pop, full, empty and level.
- Synchroniser, filter, FSM and watchdog stay in ps2_rx_frame_ctrl.

Test Plan:
- Defaults; send 0x1C with start 0, parity 0, stop 1 at a 60-cycle bit period -> one push; rx_valid=1, rx_data=0x1C, fifo_level=1; pop with rx_ready -> rx_valid=0.
- Send 0x1C with parity 1 -> err_parity pulses once, fifo_level stays 0. Send 0xF0 with parity 1 and stop 0 -> err_frame pulses once, nothing pushed.
- rx_ready=0; send frames 0x01,0x02,0x03,0x04,0x05 -> level reaches 4, err_overrun on the 5th; drain yields 0x01..0x04 in order. Repeat with rx_ready=1 in the push cycle while full -> no overrun.
- Send start plus 4 data bits, then hold ps2_clk high for 5000 cycles -> err_timeout and busy=0. Then send 0xF0 with parity 1 -> rx_data=0xF0.
- Glitch: ps2_clk low pulses of FILTER_LEN-1 cycles (3) mid-frame -> no strobe, frame decodes correctly. A pulse of 4 or more cycles counts as an edge.
- Assert reset after 6 bits -> busy=0, no error pulse, FIFO empty; the next full frame 0xAA (parity 1) is received correctly. Also test PARITY_MODE=0, DATA_BITS=7 with 0x55 -> rx_data=0x55.
